fir_tap_sequencer: RTL

- Downstream of the clock generator: consumes the divided sample clock (clkby64 level) as a plain signal in the clk domain.
- Detects each rising edge of that signal synchronously and captures one input sample into a tap delay line per edge.
- Computes one FIR output per sample using a single multiply-accumulate (MAC) unit that steps through the taps one per clk cycle.
- Presents the result with a one-cycle valid strobe to the output/display stage.

---
 rtl/fir_pkg.sv | 22 ++
 rtl/fir_tap_sequencer_tick_edge_detect.sv | 28 ++
 rtl/fir_tap_sequencer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR tap sequencer slice.
// Holds the default widths, the sequencer state encoding and a helper that
// computes the narrowest accumulator that can never overflow.
package fir_pkg;

  localparam int FIR_DATA_W = 8;   // signed sample width
  localparam int FIR_COEF_W = 8;   // signed coefficient width
  localparam int FIR_TAPS   = 8;   // number of taps
  localparam int FIR_ACC_W  = 19;  // signed accumulator / output width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } fir_state_e;

  // Full-precision product plus one bit per doubling of the tap count.
  function automatic int fir_min_acc_w(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + $clog2(taps);
  endfunction

endpackage

// File: rtl/fir_tap_sequencer_tick_edge_detect.sv
// Synchronous rising-edge detector for a divided clock level (clkby4,
// clkby64, ...) that is treated as ordinary data in the clk domain.
//   clk   : system clock
//   rst   : synchronous active-high reset
//   level : divided clock level, sampled on clk
//   rise  : high for the one cycle in which level is 1 and was 0 last cycle
// The history bit resets to 1 so a level already high when reset is released
// is not mistaken for an edge; a low-then-high transition is required.
module tick_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise
);

  logic prev_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_reg <= 1'b1;
    end else begin
      prev_reg <= level;
    end
  end

  assign rise = level & ~prev_reg;

endmodule

// File: rtl/fir_tap_sequencer.sv
// FIR tap sequencer: captures one sample per rising edge of the divided
// sample clock into a tap delay line, then walks a single multiply-accumulate
// unit through the taps (one per clk) and presents the exact sum.
//   clk, rst     : system clock, synchronous active-high reset
//   sample_tick  : divided sample clock level (clkby64)
//   din          : signed sample, captured in the edge cycle
//   coef_wr_en   : coefficient write strobe (honoured only in IDLE, no edge)
//   coef_addr    : coefficient index; indices >= TAPS are ignored
//   coef_wdata   : signed coefficient value
//   dout         : signed filter output, held until the next result
//   dout_valid   : one-cycle pulse when dout updates
//   busy         : high while the sequencer is not IDLE
//   overrun      : sticky; a tick edge arrived while busy (sample dropped)
module fir_tap_sequencer
  import fir_pkg::*;
#(
  parameter int DATA_W = FIR_DATA_W,
  parameter int COEF_W = FIR_COEF_W,
  parameter int TAPS   = FIR_TAPS,
  parameter int ACC_W  = FIR_ACC_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sample_tick,
  input  logic signed [DATA_W-1:0]   din,
  input  logic                       coef_wr_en,
  input  logic [$clog2(TAPS)-1:0]    coef_addr,
  input  logic signed [COEF_W-1:0]   coef_wdata,
  output logic signed [ACC_W-1:0]    dout,
  output logic                       dout_valid,
  output logic                       busy,
  output logic                       overrun
);

  localparam int AW     = $clog2(TAPS);
  localparam int PROD_W = DATA_W + COEF_W;

  // TAPS <= 62 keeps a whole result inside one 64-clk sample period.
  if (TAPS < 2 || TAPS > 62 || ACC_W < fir_min_acc_w(DATA_W, COEF_W, TAPS)) begin : g_bad_params
    $error("fir_tap_sequencer: illegal TAPS/ACC_W combination");
  end

  fir_state_e                state_reg;
  logic [AW-1:0]             idx_reg;
  logic signed [ACC_W-1:0]   acc_reg;
  logic signed [ACC_W-1:0]   acc_next;
  logic signed [ACC_W-1:0]   dout_reg;
  logic                      dout_valid_reg;
  logic                      overrun_reg;
  logic signed [DATA_W-1:0]  x_reg [TAPS];
  logic signed [COEF_W-1:0]  c_reg [TAPS];
  logic signed [PROD_W-1:0]  prod;
  logic                      tick_rise;
  logic                      load;
  logic                      coef_we;
  logic                      last_tap;

  tick_edge_detect u_tick_edge (
    .clk   (clk),
    .rst   (rst),
    .level (sample_tick),
    .rise  (tick_rise)
  );

  // An edge outside IDLE drops its sample; the delay line stays untouched.
  assign load = tick_rise && (state_reg == IDLE);
  // An edge has priority over a coincident coefficient write.
  assign coef_we = coef_wr_en && (state_reg == IDLE) && !tick_rise;

  // Operands are sign-extended before multiplying so the product is exact.
  assign prod     = PROD_W'(x_reg[idx_reg]) * PROD_W'(c_reg[idx_reg]);
  assign acc_next = acc_reg + ACC_W'(prod);
  assign last_tap = (idx_reg == AW'(TAPS - 1));

  // Tap delay line: x[0] takes the new sample, older samples shift down.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_reg[0] <= '0;
    end else if (load) begin
      x_reg[0] <= din;
    end
  end

  for (genvar gi = 1; gi < TAPS; gi++) begin : g_delay
    always_ff @(posedge clk) begin
      if (rst) begin
        x_reg[gi] <= '0;
      end else if (load) begin
        x_reg[gi] <= x_reg[gi-1];
      end
    end
  end

  // Coefficient bank; an address with no matching tap writes nothing.
  for (genvar gi = 0; gi < TAPS; gi++) begin : g_coef
    always_ff @(posedge clk) begin
      if (rst) begin
        c_reg[gi] <= '0;
      end else if (coef_we && (coef_addr == AW'(gi))) begin
        c_reg[gi] <= coef_wdata;
      end
    end
  end

  // Sequencer. dout/dout_valid are loaded on the final MAC step so that they
  // are registered and visible throughout the DONE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      idx_reg        <= '0;
      acc_reg        <= '0;
      dout_reg       <= '0;
      dout_valid_reg <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      dout_valid_reg <= 1'b0;
      if (tick_rise && (state_reg != IDLE)) begin
        overrun_reg <= 1'b1;
      end
      case (state_reg)
        IDLE: begin
          if (tick_rise) begin
            acc_reg   <= '0;
            idx_reg   <= '0;
            state_reg <= MAC;
          end
        end
        MAC: begin
          acc_reg <= acc_next;
          idx_reg <= idx_reg + AW'(1);
          if (last_tap) begin
            dout_reg       <= acc_next;
            dout_valid_reg <= 1'b1;
            state_reg      <= DONE;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign dout       = dout_reg;
  assign dout_valid = dout_valid_reg;
  assign busy       = (state_reg != IDLE);
  assign overrun    = overrun_reg;

endmodule
